asic_load_sched: RTL and testbench
==================================

ASIC_LOAD_SCHED -- requirements
Module: asic_load_sched

Interface
REQ-001 SHALL have parameter LOAD_WORDS, default 1104: words fed per full pass (ifmap 16 + weight 1024 + bias 64).
REQ-002 SHALL have parameter BIAS_BASE, default 1040: buffer address of the first bias word and feed length of pass 0 in mode 1.
REQ-003 SHALL have parameter OFMAP_WORDS, default 64: results collected per pass.
REQ-004 SHALL have ports: ACLK in 1, clock; ARESETn in 1, asynchronous active-low reset.
REQ-005 SHALL have ports: start in 1, one-cycle job request; mode in 1, 1 = two-pass bias feedback; irq_clr in 1, interrupt acknowledge.
REQ-006 SHALL have ports: buf_raddr out 11, buffer read address; buf_rdata in 32, read data one cycle after address.
REQ-007 SHALL have ports: buf_we out 1, buf_waddr out 11, buf_wdata out 32, bias write-back port.
REQ-008 SHALL have ports: acc_ready out 1, stream-start pulse; acc_data out 32, fed word; acc_valid in 1, result strobe; acc_ofmap in 32, result.
REQ-009 SHALL have ports: of_we out 1, of_waddr out 7, of_wdata out 32, ofmap store port.
REQ-010 SHALL have ports: irq out 1, job done; busy out 1, job in flight; err out 1, sticky timeout flag.

Function
REQ-011 SHALL implement FSM IDLE, FEED, COLLECT, DONE, plus a 1-bit pass register.
REQ-012 In IDLE, start SHALL clear pass and the counters and enter FEED; start SHALL be ignored in every state other than IDLE.
REQ-013 In FEED, buf_raddr SHALL step 0..N-1, one per cycle: N = BIAS_BASE when mode=1 and pass=0, else LOAD_WORDS.
REQ-014 Word k SHALL appear on acc_data exactly one cycle after address k; acc_ready SHALL be high only in the cycle word 0 appears.
REQ-015 FEED SHALL go to COLLECT in the cycle after word N-1 is presented.
REQ-016 acc_valid SHALL be counted in FEED and COLLECT, and ignored in IDLE and DONE.
REQ-017 Mode 1, pass 0: result j SHALL write buf_waddr = BIAS_BASE+j, buf_wdata = acc_ofmap, buf_we high.
REQ-018 Mode 1, pass 0: after OFMAP_WORDS results, the block SHALL set pass=1, clear the result count and re-enter FEED.
REQ-019 Final pass: result j SHALL write of_waddr = j (7-bit, wraps mod 128) with of_we high, zero-latency passthrough.
REQ-020 Final pass: after OFMAP_WORDS results, the block SHALL enter DONE.
REQ-021 In DONE, irq SHALL be a level output; irq_clr SHALL return to IDLE, and irq SHALL fall the following cycle.
REQ-022 busy SHALL be high in FEED, COLLECT and DONE.
REQ-023 A result arriving in the same cycle as the final FEED word SHALL be written and counted normally.
REQ-024 All counters SHALL be 11-bit unsigned and SHALL NOT wrap within a job.

Reset
REQ-025 Asserting ARESETn low SHALL immediately force IDLE, pass=0, all counters 0, and all outputs 0, including mid-job.
REQ-026 After reset deassertion, the block SHALL need a new start; no partial job resumes.

Configuration
REQ-027 With ASIC_SCHED_TIMEOUT_EN defined, a 16-bit watchdog SHALL count COLLECT cycles since the last acc_valid.
REQ-028 With ASIC_SCHED_TIMEOUT_EN defined, reaching parameter TIMEOUT_CYCLES (default 4096) SHALL set err (sticky until start) and enter DONE.
REQ-029 Without ASIC_SCHED_TIMEOUT_EN, err SHALL be tied 0 and no watchdog logic SHALL exist.

Structure
REQ-030 Package asic_sched_pkg SHALL hold the state enum, the 11-bit address type, and the defaults 1104/1040/64/4096.
REQ-031 Sub-module asic_sched_feed SHALL hold the read-address counter, the one-cycle data alignment stage and acc_ready generation.

Verification
REQ-032 Mode 0: buffer[k]=k, start -> acc_ready once with acc_data=0; 1104 consecutive words; 64 valids give of_waddr 0..63; irq high.
REQ-033 Mode 1: pass 0 feeds 1040 words; results 0xA0+j write buf 1040+j; pass 1 feeds 1104 words with buf[1040]=0xA0; 64 ofmap writes; irq.
REQ-034 start pulsed during FEED at word 500 -> no restart; addresses continue 501, 502, ...
REQ-035 ARESETn low at FEED word 300 -> all outputs 0 immediately; a new start after release begins at address 0.
REQ-036 With ASIC_SCHED_TIMEOUT_EN and TIMEOUT_CYCLES=16, stop acc_valid after 10 results -> err=1 and irq=1 at 16 idle cycles.
REQ-037 irq_clr in DONE -> irq=0 and busy=0 on the next cycle; acc_valid in IDLE -> no of_we.

Source files
------------

// File: rtl/asic_sched_pkg.sv
// Shared types and default sizing for the load scheduler.
package asic_sched_pkg;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_FEED    = 2'd1,
      S_COLLECT = 2'd2,
      S_DONE    = 2'd3
   } state_t;

   typedef logic [10:0] addr_t;

   localparam int LOAD_WORDS_DEF     = 1104;
   localparam int BIAS_BASE_DEF      = 1040;
   localparam int OFMAP_WORDS_DEF    = 64;
   localparam int TIMEOUT_CYCLES_DEF = 4096;

endpackage

// File: rtl/asic_sched_feed.sv
// Buffer read-address sequencer with one-cycle data alignment and stream-start pulse.
module asic_sched_feed
   import asic_sched_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_start,
   input  logic        i_run,
   input  addr_t       i_len,
   input  logic [31:0] i_rdata,
   output addr_t       o_raddr,
   output logic [31:0] o_data,
   output logic        o_ready,
   output logic        o_last
);

   addr_t r_raddr;
   logic  r_active;
   logic  r_dvalid;
   logic  r_first;
   logic  r_last;
   addr_t w_last_addr;

   assign w_last_addr = i_len - addr_t'(1);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_raddr  <= '0;
         r_active <= 1'b0;
         r_dvalid <= 1'b0;
         r_first  <= 1'b0;
         r_last   <= 1'b0;
      end else if (i_start) begin
         r_raddr  <= '0;
         r_active <= 1'b1;
         r_dvalid <= 1'b0;
         r_first  <= 1'b0;
         r_last   <= 1'b0;
      end else if (!i_run) begin
         r_active <= 1'b0;
         r_dvalid <= 1'b0;
         r_first  <= 1'b0;
         r_last   <= 1'b0;
      end else begin
         // flags describe the word that the buffer returns in the next cycle
         r_dvalid <= r_active;
         r_first  <= r_active && (r_raddr == '0);
         r_last   <= r_active && (r_raddr == w_last_addr);
         if (r_active) begin
            if (r_raddr == w_last_addr) r_active <= 1'b0;
            else                        r_raddr  <= r_raddr + addr_t'(1);
         end
      end
   end

   assign o_raddr = r_raddr;
   assign o_data  = (i_run && r_dvalid) ? i_rdata : '0;
   assign o_ready = i_run && r_first;
   assign o_last  = i_run && r_last;

endmodule

// File: rtl/asic_load_sched.sv
// Accelerator load scheduler: streams buffer words, collects results, optional bias feedback pass.
// Define ASIC_SCHED_TIMEOUT_EN to build the COLLECT-phase watchdog that drives err.
//
// state     | meaning
// S_IDLE    | waiting for start
// S_FEED    | streaming buffer words to the accelerator
// S_COLLECT | feed finished, waiting for remaining results
// S_DONE    | job finished, irq held until irq_clr
module asic_load_sched
   import asic_sched_pkg::*;
#(
   parameter int LOAD_WORDS  = LOAD_WORDS_DEF,
   parameter int BIAS_BASE   = BIAS_BASE_DEF,
   parameter int OFMAP_WORDS = OFMAP_WORDS_DEF
`ifdef ASIC_SCHED_TIMEOUT_EN
   ,
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
`endif
)(
   input  logic        ACLK,
   input  logic        ARESETn,
   input  logic        start,
   input  logic        mode,
   input  logic        irq_clr,
   output logic [10:0] buf_raddr,
   input  logic [31:0] buf_rdata,
   output logic        buf_we,
   output logic [10:0] buf_waddr,
   output logic [31:0] buf_wdata,
   output logic        acc_ready,
   output logic [31:0] acc_data,
   input  logic        acc_valid,
   input  logic [31:0] acc_ofmap,
   output logic        of_we,
   output logic [6:0]  of_waddr,
   output logic [31:0] of_wdata,
   output logic        irq,
   output logic        busy,
   output logic        err
);

   state_t r_state;
   logic   r_pass;
   logic   r_mode;
   addr_t  r_res_cnt;

   logic   w_take;
   logic   w_bias_pass;
   logic   w_pass_done;
   logic   w_feed_start;
   logic   w_feed_last;
   logic   w_timeout;
   addr_t  w_feed_len;

   assign w_take       = acc_valid && ((r_state == S_FEED) || (r_state == S_COLLECT));
   assign w_bias_pass  = r_mode && !r_pass;
   assign w_pass_done  = w_take && (r_res_cnt == addr_t'(OFMAP_WORDS - 1));
   assign w_feed_start = ((r_state == S_IDLE) && start) || (w_pass_done && w_bias_pass);
   assign w_feed_len   = w_bias_pass ? addr_t'(BIAS_BASE) : addr_t'(LOAD_WORDS);

   asic_sched_feed u_feed (
      .i_clk   (ACLK),
      .i_rst_n (ARESETn),
      .i_start (w_feed_start),
      .i_run   (r_state == S_FEED),
      .i_len   (w_feed_len),
      .i_rdata (buf_rdata),
      .o_raddr (buf_raddr),
      .o_data  (acc_data),
      .o_ready (acc_ready),
      .o_last  (w_feed_last)
   );

`ifdef ASIC_SCHED_TIMEOUT_EN
   logic [15:0] r_wdog;
   logic        r_err;

   assign w_timeout = (r_state == S_COLLECT) && !w_take &&
                      (r_wdog == 16'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         r_wdog <= '0;
         r_err  <= 1'b0;
      end else begin
         if ((r_state != S_COLLECT) || w_take) r_wdog <= '0;
         else if (!w_timeout)                  r_wdog <= r_wdog + 16'd1;
         if ((r_state == S_IDLE) && start) r_err <= 1'b0;
         else if (w_timeout)               r_err <= 1'b1;
      end
   end

   assign err = r_err;
`else
   assign w_timeout = 1'b0;
   assign err       = 1'b0;
`endif

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         r_state   <= S_IDLE;
         r_pass    <= 1'b0;
         r_mode    <= 1'b0;
         r_res_cnt <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_state   <= S_FEED;
                  r_pass    <= 1'b0;
                  r_mode    <= mode;
                  r_res_cnt <= '0;
               end
            end
            S_FEED, S_COLLECT: begin
               if (w_pass_done) begin
                  r_res_cnt <= '0;
                  if (w_bias_pass) begin
                     r_pass  <= 1'b1;
                     r_state <= S_FEED;
                  end else begin
                     r_state <= S_DONE;
                  end
               end else begin
                  if (w_take) r_res_cnt <= r_res_cnt + addr_t'(1);
                  if (w_timeout)                               r_state <= S_DONE;
                  else if ((r_state == S_FEED) && w_feed_last) r_state <= S_COLLECT;
               end
            end
            S_DONE: begin
               if (irq_clr) r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // result writes are combinational so a result is stored in the cycle it arrives
   assign buf_we    = w_take && w_bias_pass;
   assign buf_waddr = buf_we ? (addr_t'(BIAS_BASE) + r_res_cnt) : '0;
   assign buf_wdata = buf_we ? acc_ofmap : '0;
   assign of_we     = w_take && !w_bias_pass;
   assign of_waddr  = of_we ? r_res_cnt[6:0] : '0;
   assign of_wdata  = of_we ? acc_ofmap : '0;

   assign irq  = (r_state == S_DONE);
   assign busy = (r_state != S_IDLE);

endmodule

// File: tb/tb_asic_load_sched.sv
// Scoreboard bench for asic_load_sched: directed jobs, expected writes queued at stimulus time.
module tb_asic_load_sched;

   localparam int LW = 1104;
   localparam int BB = 1040;
   localparam int OW = 64;

   logic        ACLK = 1'b0;
   logic        ARESETn = 1'b0;
   logic        start = 1'b0;
   logic        mode = 1'b0;
   logic        irq_clr = 1'b0;
   logic        acc_valid = 1'b0;
   logic [31:0] acc_ofmap = '0;
   logic [31:0] buf_rdata;
   logic [10:0] buf_raddr;
   logic        buf_we;
   logic [10:0] buf_waddr;
   logic [31:0] buf_wdata;
   logic        acc_ready;
   logic [31:0] acc_data;
   logic        of_we;
   logic [6:0]  of_waddr;
   logic [31:0] of_wdata;
   logic        irq;
   logic        busy;
   logic        err;

   always #5 ACLK = ~ACLK;

   asic_load_sched #(
      .LOAD_WORDS  (LW),
      .BIAS_BASE   (BB),
      .OFMAP_WORDS (OW)
`ifdef ASIC_SCHED_TIMEOUT_EN
      ,
      .TIMEOUT_CYCLES (16)
`endif
   ) dut (
      .ACLK      (ACLK),
      .ARESETn   (ARESETn),
      .start     (start),
      .mode      (mode),
      .irq_clr   (irq_clr),
      .buf_raddr (buf_raddr),
      .buf_rdata (buf_rdata),
      .buf_we    (buf_we),
      .buf_waddr (buf_waddr),
      .buf_wdata (buf_wdata),
      .acc_ready (acc_ready),
      .acc_data  (acc_data),
      .acc_valid (acc_valid),
      .acc_ofmap (acc_ofmap),
      .of_we     (of_we),
      .of_waddr  (of_waddr),
      .of_wdata  (of_wdata),
      .irq       (irq),
      .busy      (busy),
      .err       (err)
   );

   // buffer model: registered read, write-back port, filled with buf[k]=k
   logic [31:0] mem [0:2047];
   bit          mem_filled = 1'b0;
   always @(posedge ACLK) begin
      if (!mem_filled) begin
         for (int k = 0; k < 2048; k++) mem[k] <= 32'(k);
         mem_filled <= 1'b1;
      end else if (buf_we) begin
         mem[buf_waddr] <= buf_wdata;
      end
      buf_rdata <= mem[buf_raddr];
   end

   typedef struct packed {
      logic        is_of;
      logic [10:0] addr;
      logic [31:0] data;
   } wr_t;

   wr_t exp_q[$];
   int  n_checks = 0;
   int  n_errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   function automatic logic [31:0] exp_word(input int k, input bit bias_over);
      if (bias_over && k >= BB) return 32'hA0 + 32'(k - BB);
      return 32'(k);
   endfunction

   // monitor: every write the DUT presents must match the oldest queued expectation
   initial begin
      wr_t e;
      forever begin
         @(negedge ACLK);
         #2;
         if (of_we || buf_we) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_write", {62'd0, of_we, buf_we}, 64'd0);
            end else begin
               e = exp_q.pop_front();
               chk("write_port", of_we, e.is_of);
               chk("write_addr", e.is_of ? {4'd0, of_waddr} : buf_waddr, e.addr);
               chk("write_data", e.is_of ? of_wdata : buf_wdata, e.data);
            end
         end
      end
   end

   task automatic drive_result(input bit is_of, input int idx, input logic [31:0] d);
      wr_t e;
      acc_valid = 1'b1;
      acc_ofmap = d;
      e.is_of = is_of;
      e.addr  = is_of ? 11'(idx % 128) : 11'(BB + idx);
      e.data  = d;
      exp_q.push_back(e);
   endtask

   task automatic send_results(input int first, input int count, input logic [31:0] base,
                               input bit is_of);
      for (int j = first; j < first + count; j++) begin
         @(negedge ACLK);
         if (j % 5 == 3) begin
            acc_valid = 1'b0;
            @(negedge ACLK);
         end
         drive_result(is_of, j, base + 32'(j));
      end
      @(negedge ACLK);
      acc_valid = 1'b0;
   endtask

   task automatic pulse_start();
      @(negedge ACLK);
      start = 1'b1;
      @(negedge ACLK);
      start = 1'b0;
   endtask

   task automatic run_feed(input int n, input bit bias_over, input bit send_last,
                           input int start_at, input int stop_at);
      int t;
      int bad;
      t   = 0;
      bad = 0;
      do begin
         @(negedge ACLK);
         t++;
      end while (!acc_ready && t < 50);
      chk("ready_seen", acc_ready, 1);
      chk("word0", acc_data, exp_word(0, bias_over));
      chk("busy_feed", busy, 1);
      for (int k = 1; k < n; k++) begin
         @(negedge ACLK);
         if (acc_ready !== 1'b0 || acc_data !== exp_word(k, bias_over)) bad++;
         start = (k == start_at);
         if (k == stop_at) begin
            chk("words_to_stop", bad, 0);
            return;
         end
         if (send_last && k == n - 1) drive_result(1'b1, 0, 32'h100);
      end
      @(negedge ACLK);
      start     = 1'b0;
      acc_valid = 1'b0;
      chk("feed_words", bad, 0);
      chk("feed_end", {acc_ready, acc_data}, 0);
   endtask

   task automatic finish_job();
      int t;
      t = 0;
      while (!irq && t < 20) begin
         @(negedge ACLK);
         t++;
      end
      chk("irq_set", irq, 1);
      chk("busy_done", busy, 1);
      irq_clr = 1'b1;
      @(negedge ACLK);
      irq_clr = 1'b0;
      chk("irq_clr_irq", irq, 0);
      chk("irq_clr_busy", busy, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "bench time limit");
   end

   initial begin
      repeat (3) @(negedge ACLK);
      chk("reset_ctl", {irq, busy, err, buf_we, of_we, acc_ready}, 0);
      chk("reset_raddr", buf_raddr, 0);
      ARESETn = 1'b1;
      repeat (2) @(negedge ACLK);

      // mode 0 job, first result coincides with the final feed word
      mode = 1'b0;
      pulse_start();
      run_feed(LW, 1'b0, 1'b1, -1, -1);
      send_results(1, OW - 1, 32'h100, 1'b1);
      finish_job();
      chk("err_clear", err, 0);

      // results in IDLE are ignored
      @(negedge ACLK);
      acc_valid = 1'b1;
      acc_ofmap = 32'hDEAD;
      #2;
      chk("idle_no_write", {of_we, buf_we}, 0);
      @(negedge ACLK);
      acc_valid = 1'b0;

      // start during feed is ignored
      pulse_start();
      run_feed(LW, 1'b0, 1'b1, 500, -1);
      send_results(1, OW - 1, 32'h100, 1'b1);
      finish_job();

      // reset mid-feed, then a fresh job from address 0
      pulse_start();
      run_feed(LW, 1'b0, 1'b0, -1, 300);
      ARESETn = 1'b0;
      #1;
      chk("midrst_ctl", {irq, busy, err, buf_we, of_we, acc_ready}, 0);
      chk("midrst_raddr", buf_raddr, 0);
      chk("midrst_data", acc_data, 0);
      chk("midrst_waddr", {buf_waddr, of_waddr}, 0);
      chk("midrst_wdata", {buf_wdata, of_wdata}, 0);
      @(negedge ACLK);
      ARESETn = 1'b1;
      repeat (5) @(negedge ACLK);
      chk("no_resume", {busy, acc_ready}, 0);
      pulse_start();
      run_feed(LW, 1'b0, 1'b1, -1, -1);
      send_results(1, OW - 1, 32'h100, 1'b1);
      finish_job();

`ifdef ASIC_SCHED_TIMEOUT_EN
      begin
         int t;
         pulse_start();
         run_feed(LW, 1'b0, 1'b0, -1, -1);
         send_results(0, 10, 32'h400, 1'b1);
         t = 0;
         while (!irq && t < 40) begin
            @(negedge ACLK);
            t++;
         end
         chk("timeout_cycles", t, 16);
         chk("timeout_err", err, 1);
         chk("timeout_irq", irq, 1);
         irq_clr = 1'b1;
         @(negedge ACLK);
         irq_clr = 1'b0;
         chk("err_sticky", err, 1);
         pulse_start();
         chk("err_cleared_by_start", err, 0);
         ARESETn = 1'b0;
         @(negedge ACLK);
         ARESETn = 1'b1;
         @(negedge ACLK);
      end
`endif

      // mode 1: bias pass writes back, final pass reads the written bias
      mode = 1'b1;
      pulse_start();
      run_feed(BB, 1'b0, 1'b0, -1, -1);
      send_results(0, OW, 32'hA0, 1'b0);
      run_feed(LW, 1'b1, 1'b0, -1, -1);
      send_results(0, OW, 32'h200, 1'b1);
      finish_job();

      repeat (3) @(negedge ACLK);
      chk("queue_drained", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
